adc_val_packer: RTL

- Sits directly downstream of the ADC driver's scaled-value output (8-bit val_out / val_valid).
- Packs successive 8-bit values into 128-bit words.
- Buffers the words in a small FIFO and streams them to the PS DMA as AXI-Stream frames with tlast.
- Lets software read back exactly the values the experiment FSM consumed, with overflow detection and frame counting.

---
 rtl/adc_val_packer_pkg.sv | 21 ++
 rtl/adc_val_packer_axis_word_fifo.sv | 82 ++++++++
 rtl/adc_val_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/adc_val_packer_pkg.sv
// Shared types and constants for the ADC value packer: lane geometry,
// packer FSM encoding and the word format stored in the output FIFO.
package adc_pkg;

  localparam int VAL_W  = 8;
  localparam int AXIS_W = 128;
  localparam int LANES  = AXIS_W / VAL_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } packer_state_t;

  // tlast travels with its data word through the FIFO.
  typedef struct packed {
    logic [AXIS_W-1:0] data;
    logic              last;
  } word_t;

endpackage

// File: rtl/adc_val_packer_axis_word_fifo.sv
// Synchronous word FIFO with a registered AXI-Stream head. The output
// register counts as one of the FIFO_DEPTH entries, so total occupancy
// (memory plus head register) never exceeds FIFO_DEPTH. A pushed word
// lands in memory first and moves to the head register one clock later.
module axis_word_fifo
  import adc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  word_t             push_word,
  output logic              full,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  word_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_cnt;
  logic [CNT_W-1:0] occupancy;
  logic             out_vld;
  word_t            out_word;
  logic             mem_empty;
  logic             pop;
  logic             push_ok;
  logic             load;

  assign occupancy = mem_cnt + CNT_W'(out_vld);
  assign full      = (occupancy == CNT_W'(FIFO_DEPTH));
  assign mem_empty = (mem_cnt == '0);
  assign pop       = out_vld && m_axis_tready;
  // A pop in the same cycle frees the head slot, so a push while full still fits.
  assign push_ok   = push && (!full || pop);
  assign load      = (!out_vld || pop) && !mem_empty;

  assign m_axis_tdata  = out_word.data;
  assign m_axis_tlast  = out_word.last;
  assign m_axis_tvalid = out_vld;

  // Storage write; contents are only meaningful where mem_cnt says so.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers, occupancy and the registered AXIS head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      out_vld  <= 1'b0;
      out_word <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_word <= mem[rd_ptr];
        out_vld  <= 1'b1;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
      case ({push_ok, load})
        2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
        2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: rtl/adc_val_packer.sv
// Packs 8-bit ADC values into 128-bit words (lane 0 in the low byte),
// tags the last word of each frame and streams the words out through a
// small FIFO. A falling edge of run flushes any partial word or frame.
module adc_val_packer
  import adc_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 64,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [VAL_W-1:0] val_in,
  input  logic                    val_valid,
  input  logic                    run,
  input  logic                    clear_ovf,
  output logic [AXIS_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    overflow,
  output logic [15:0]             frame_count
);

  localparam int LANE_W = $clog2(LANES);

  packer_state_t     state;
  logic [LANE_W-1:0] lane_cnt;
  logic [15:0]       word_cnt;
  logic [AXIS_W-1:0] acc;
  logic              accept;
  logic              word_done;
  logic              at_frame_end;
  logic              flush_push;
  logic              vld_p0;
  word_t             word_p0;
  logic              fifo_full;
  logic              drop;

  assign accept       = (state == COLLECT) && run && val_valid;
  assign word_done    = accept && (lane_cnt == LANE_W'(LANES - 1));
  assign at_frame_end = (word_cnt == 16'(WORDS_PER_FRAME - 1));
  // Flush closes the frame: partial word if any lanes are filled, else an
  // all-zero word if the frame is open, else nothing.
  assign flush_push   = (state == FLUSH) && ((lane_cnt != '0) || (word_cnt != '0));
  // Dropped words still advance the counters, keeping frame alignment.
  assign drop         = vld_p0 && fifo_full && !(m_axis_tvalid && m_axis_tready);

  // Capture FSM: run rising starts collection, run falling costs one flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (run) state <= COLLECT;
        COLLECT: if (!run) state <= FLUSH;
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane accumulation and word/frame counting; acc is cleared whenever a
  // word leaves so a partial flush carries zeros in its unused lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt    <= '0;
      word_cnt    <= '0;
      acc         <= '0;
      frame_count <= '0;
      vld_p0      <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (state == FLUSH) begin
        lane_cnt <= '0;
        word_cnt <= '0;
        acc      <= '0;
        if (flush_push) begin
          vld_p0      <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end else if (accept) begin
        lane_cnt <= lane_cnt + LANE_W'(1);
        if (word_done) begin
          vld_p0   <= 1'b1;
          acc      <= '0;
          word_cnt <= at_frame_end ? 16'd0 : word_cnt + 16'd1;
          if (at_frame_end) begin
            frame_count <= frame_count + 16'd1;
          end
        end else begin
          acc[lane_cnt*VAL_W +: VAL_W] <= val_in;
        end
      end
    end
  end

  // ---- stage p0: completed word registered, written to the FIFO next edge ----
  // Word payload register; qualified by vld_p0.
  always_ff @(posedge clk) begin
    if (flush_push) begin
      word_p0 <= '{data: acc, last: 1'b1};
    end else if (word_done) begin
      word_p0 <= '{data: {val_in, acc[AXIS_W-VAL_W-1:0]}, last: at_frame_end};
    end
  end

  // Sticky overflow; a fresh drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  axis_word_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (vld_p0),
    .push_word    (word_p0),
    .full         (fifo_full),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

endmodule
